// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit ALU slice evaluated per clock, LSB first, carry held in a flop.
// Optional macro SERIAL_OVF_EN adds the signed-overflow output ovf.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
`ifdef SERIAL_OVF_EN
    output logic             zero,
    output logic             ovf
`else
    output logic             zero
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [2:0]       r_op;
    logic             r_cf;
    logic [CNT_W-1:0] r_cnt;

    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;

    logic             w_b_eff;
    logic             w_sum;
    logic             w_cgen;
    logic             w_slice_out;
    logic             w_slice_cout;
    logic             w_arith;
    logic [WIDTH-1:0] w_result_nxt;

    // Single 1-bit ALU slice; b is inverted for SUB, logic ops never generate a carry
    always_comb begin
        w_b_eff      = (r_op == OP_SUB) ? ~r_b_sh[0] : r_b_sh[0];
        w_sum        = r_a_sh[0] ^ w_b_eff ^ r_cf;
        w_cgen       = (r_a_sh[0] & w_b_eff) | (r_cf & (r_a_sh[0] ^ w_b_eff));
        w_slice_out  = r_a_sh[0];
        w_slice_cout = 1'b0;
        w_arith      = 1'b0;
        case (r_op)
            OP_NOT:  w_slice_out = ~r_a_sh[0];
            OP_NAND: w_slice_out = ~(r_a_sh[0] & r_b_sh[0]);
            OP_NOR:  w_slice_out = ~(r_a_sh[0] | r_b_sh[0]);
            OP_ADD, OP_SUB: begin
                w_slice_out  = w_sum;
                w_slice_cout = w_cgen;
                w_arith      = 1'b1;
            end
            default: w_slice_out = r_a_sh[0];
        endcase
    end

    assign w_result_nxt = {w_slice_out, r_result[WIDTH-1:1]};

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                    w_last      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != S_RUN);
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= w_last;
        end
    end

    // Datapath: operand shifters, carry flop, counter and result/flag capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_op     <= 3'b000;
            r_cf     <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_op   <= select;
            r_cf   <= (select == OP_SUB);
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_result <= w_result_nxt;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_cf     <= w_slice_cout;
            if (w_last) begin
                r_carry <= w_arith & w_slice_cout;
                r_zero  <= (w_result_nxt == '0);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= w_arith & (r_cf ^ w_slice_cout);
        end
    end

    assign ovf = r_ovf;
`endif

    assign ready  = r_ready;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: directed plan cases plus randomized operations
// checked against an arithmetic reference model.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   select;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
`ifdef SERIAL_OVF_EN
    logic         ovf;
`endif

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .select (select),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
`ifdef SERIAL_OVF_EN
        .zero   (zero),
        .ovf    (ovf)
`else
        .zero   (zero)
`endif
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
        int           dc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy_run = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model from the opcode table, using whole-word arithmetic
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int dc);
        exp_t       e;
        logic [W:0] s;
        e.c  = 1'b0;
        e.v  = 1'b0;
        e.dc = dc;
        case (op)
            3'b001: e.res = ~x;
            3'b011: e.res = ~(x & y);
            3'b100: e.res = ~(x | y);
            3'b110: begin
                s     = {1'b0, x} + {1'b0, y};
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            3'b101: begin
                e.res = x - y;
                e.c   = (x >= y);
                e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            default: e.res = x;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
        end else begin
            select = op;
            a      = x;
            b      = y;
            start  = 1'b1;
            sb.push_back(model(op, x, y, cyc + 1 + int'(W)));
            @(negedge clk);
            start  = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else if (done) begin
                chk("busy_len", 32'(busy_run), 32'(W));
                busy_run = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("carry", 32'(carry), 32'(e.c));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("done_cycle", 32'(cyc), 32'(e.dc));
                    chk("ready_in_done", 32'(ready), 32'd1);
`ifdef SERIAL_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.v));
`endif
                end
            end else begin
                busy_run = 0;
            end
        end
    end

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        select = 3'b000;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(3'b110, 8'h7F, 8'h01);
        issue(3'b101, 8'h07, 8'h05);
        issue(3'b101, 8'h05, 8'h07);
        issue(3'b011, 8'hF0, 8'hCC);
        issue(3'b100, 8'hF0, 8'h0C);
        issue(3'b001, 8'h5A, 8'h00);
        issue(3'b000, 8'h3C, 8'h00);
        issue(3'b111, 8'h00, 8'h00);

        // A start pulse in RUN must be ignored
        issue(3'b110, 8'h11, 8'h22);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;

        // Reset in the fourth RUN cycle aborts without a done pulse
        issue(3'b110, 8'h40, 8'h40);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sb.pop_back();
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_carry", 32'(carry), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        reset = 1'b0;
        issue(3'b110, 8'h01, 8'h01);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(3'($urandom_range(0, 7)), 8'($urandom()), 8'($urandom()));
        end

        n = 0;
        while (sb.size() > 0 && n < 4 * int'(W)) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
